// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter and its grant helper.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  // Bit positions inside the 6-bit {err,e,l,g,cout,oflow} flag vector
  localparam int unsigned OFLOW = 0;
  localparam int unsigned COUT  = 1;
  localparam int unsigned G     = 2;
  localparam int unsigned L     = 3;
  localparam int unsigned E     = 4;
  localparam int unsigned ERR   = 5;

  localparam logic [5:0] FLAGS_ERR_ONLY = 6'b1 << ERR;

  localparam int unsigned MUL_CMD_A = 9;
  localparam int unsigned MUL_CMD_B = 10;

endpackage

// File: rtl/alu_rr_grant.sv
// Two-way round-robin grant: on a tie the requester that is not the pointer wins.
module alu_rr_grant (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two valid/ready requesters; one op in flight, tagged responses.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CMD_WIDTH = 4,
  parameter int unsigned LAT       = 1,
  parameter int unsigned MUL_LAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*WIDTH-1:0]     req_opa,
  input  logic [2*WIDTH-1:0]     req_opb,
  input  logic [1:0]             req_mode,
  input  logic [1:0]             req_cin,
  input  logic [3:0]             req_inp_valid,
  input  logic [2*CMD_WIDTH-1:0] req_cmd,
  output logic [WIDTH-1:0]       alu_opa,
  output logic [WIDTH-1:0]       alu_opb,
  output logic                   alu_ce,
  output logic                   alu_mode,
  output logic                   alu_cin,
  output logic [1:0]             alu_inp_valid,
  output logic [CMD_WIDTH-1:0]   alu_cmd,
  input  logic [WIDTH:0]         alu_res,
  input  logic [5:0]             alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [WIDTH:0]         rsp_res,
  output logic [5:0]             rsp_flags,
  output logic [15:0]            op_count
);

  localparam int unsigned MAX_LAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  arb_state_t             state;
  logic                   pointer;
  logic [1:0]             grant;
  logic [CNT_W-1:0]       lat_cnt;
  logic                   sel;
  logic                   handshake;
  logic                   is_mul;
  logic [WIDTH-1:0]       sel_opa;
  logic [WIDTH-1:0]       sel_opb;
  logic                   sel_mode;
  logic                   sel_cin;
  logic [1:0]             sel_inp_valid;
  logic [CMD_WIDTH-1:0]   sel_cmd;

  alu_rr_grant u_grant (
    .valid   (req_valid),
    .pointer (pointer),
    .grant   (grant)
  );

  // Gated with rst so no request can be acknowledged in a cycle that resets.
  assign req_ready = (rst && state == IDLE) ? grant : '0;
  assign handshake = |(req_valid & req_ready);
  assign sel       = grant[1];

  always_comb begin
    sel_opa       = sel ? req_opa[WIDTH +: WIDTH]         : req_opa[0 +: WIDTH];
    sel_opb       = sel ? req_opb[WIDTH +: WIDTH]         : req_opb[0 +: WIDTH];
    sel_mode      = sel ? req_mode[1]                     : req_mode[0];
    sel_cin       = sel ? req_cin[1]                      : req_cin[0];
    sel_inp_valid = sel ? req_inp_valid[3:2]              : req_inp_valid[1:0];
    sel_cmd       = sel ? req_cmd[CMD_WIDTH +: CMD_WIDTH] : req_cmd[0 +: CMD_WIDTH];
  end

  // The alu_* registers double as the captured copy of the granted request.
  assign is_mul = alu_mode && (alu_cmd == CMD_WIDTH'(MUL_CMD_A) ||
                               alu_cmd == CMD_WIDTH'(MUL_CMD_B));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      pointer       <= 1'b1;
      lat_cnt       <= '0;
      alu_opa       <= '0;
      alu_opb       <= '0;
      alu_ce        <= 1'b0;
      alu_mode      <= 1'b0;
      alu_cin       <= 1'b0;
      alu_inp_valid <= '0;
      alu_cmd       <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_res       <= '0;
      rsp_flags     <= '0;
      op_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            rsp_id <= sel;
            if (sel_inp_valid == 2'b00) begin
              rsp_res   <= '0;
              rsp_flags <= FLAGS_ERR_ONLY;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_opa       <= sel_opa;
              alu_opb       <= sel_opb;
              alu_mode      <= sel_mode;
              alu_cin       <= sel_cin;
              alu_inp_valid <= sel_inp_valid;
              alu_cmd       <= sel_cmd;
              alu_ce        <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          lat_cnt  <= is_mul ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
          op_count <= op_count + 16'd1;
          state    <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == CNT_W'(1)) begin
            rsp_res       <= alu_res;
            rsp_flags     <= alu_flags;
            rsp_valid     <= 1'b1;
            alu_ce        <= 1'b0;
            alu_inp_valid <= '0;
            state         <= RESP;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            pointer   <= rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one ALU instance between two independent requesters (e.g. a directed stimulus path and a background/self-check path). Each request uses a valid/ready handshake. A round-robin grant selects one request at a time, and the block drives the ALU operand/command pins with ce held for the operation's latency. It captures the result and flags, then returns them on a single response channel tagged with the requester id. Only one operation is in flight at a time, so responses are always in order.

Parameters:
WIDTH, 8, operand width (matches `WIDTH)
CMD_WIDTH, 4, command width (matches `CMD_WIDTH)
LAT, 1, result latency in cycles for all non-multiply commands (>=1)
MUL_LAT, 2, result latency for multiply commands (mode=1, cmd 9 or 10) (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept (one-hot or zero)
req_opa  in  2*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH]
req_opb  in  2*WIDTH  operand B, sliced as req_opa
req_mode  in  2  mode per requester
req_cin  in  2  carry-in per requester
req_inp_valid  in  4  inp_valid per requester, 2 bits each
req_cmd  in  2*CMD_WIDTH  command per requester
alu_opa, alu_opb  out  WIDTH  ALU operands
alu_ce  out  1  ALU clock enable
alu_mode, alu_cin  out  1  ALU mode, carry-in
alu_inp_valid  out  2  ALU inp_valid
alu_cmd  out  CMD_WIDTH  ALU command
alu_res  in  WIDTH+1  ALU result
alu_flags  in  6  {err,e,l,g,cout,oflow} from ALU
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  1  requester served
rsp_res  out  WIDTH+1  captured result
rsp_flags  out  6  captured {err,e,l,g,cout,oflow}
op_count  out  16  count of operations issued to the ALU; wraps 0xFFFF->0

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM goes to IDLE and any in-flight op is dropped (its response is never produced).
  - All outputs go to 0: alu_*, rsp_*, req_ready, op_count.
  - Round-robin pointer set to 1, so requester 0 wins the first tie.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - alu_ce=0 and alu_inp_valid=00.
  - Grant goes to the only valid requester. If both are valid, it goes to the requester != pointer.
  - req_ready[grant]=1 combinationally, only in IDLE.
  - On handshake, capture that requester's fields and go to ISSUE.
- Zero-operand request (captured inp_valid==00): skip the ALU. Go straight to RESP with rsp_res=0, rsp_flags=6'b100000 (err=1). op_count is not incremented.
- ISSUE (1 cycle, call it T):
  - Drive alu_* from the captured fields with alu_ce=1.
  - Load the latency counter with LAT or MUL_LAT. Multiply = mode==1 and cmd in {9,10}.
  - op_count increments at the end of T. Go to WAIT.
- WAIT:
  - alu_ce=1 and operands are held stable.
  - Counter decrements each cycle.
  - In the cycle where counter==1 (i.e. cycle T+latency), capture alu_res/alu_flags into rsp_res/rsp_flags at the closing edge. Go to RESP.
- RESP:
  - alu_ce=0 and alu_inp_valid=00.
  - rsp_valid=1, with rsp_id/rsp_res/rsp_flags held stable until rsp_ready.
  - On the rsp_valid && rsp_ready edge: pointer := rsp_id, go to IDLE.
  - No new grant occurs in the RESP cycle.
- Latency from request handshake edge to first rsp_valid cycle = latency+2 cycles. Minimum issue rate is one op per latency+3 cycles.
- A requester that drops req_valid before being granted is simply not served; no state is kept for it.
- Request field changes after the handshake have no effect on the in-flight op.

Decomposition:
- Shared package alu_arb_pkg: state enum (IDLE/ISSUE/WAIT/RESP), flag-bit index constants (OFLOW=0 … ERR=5), multiply command constants MUL_CMD_A=9 and MUL_CMD_B=10.
- One sub-module: alu_rr_grant, a 2-way round-robin grant (valid[1:0], pointer -> grant one-hot). It is combinational and reusable by the team's other shared-resource blocks.

Test Plan:
1. Single ADD, LAT=1: req0 with mode=1, cmd=0, opa=200, opb=100, inp_valid=11 -> ce=1 for 2 cycles, rsp_valid 3 cycles after the handshake, rsp_id=0, rsp_res=9'd300, cout=1, op_count=1.
2. Tie and fairness: both requesters valid continuously from reset -> grants alternate 0,1,0,1. Each response carries the matching id and result.
3. Multiply, MUL_LAT=2: req1 with mode=1, cmd=9, opa=15, opb=15 -> ce held 3 cycles, rsp_res=9'd256 (ALU multiply of (a+1)*(b+1)), rsp_id=1.
4. Zero-operand request: req0 with inp_valid=00 -> alu_ce never asserts, rsp_flags=100000, rsp_res=0, op_count unchanged.
5. Backpressure: rsp_ready held low for 5 cycles -> rsp fields stable, req_ready stays 0 for a waiting req1, and req1 is granted the cycle after the handshake.
6. Reset mid-WAIT: rst=0 for one edge during WAIT -> all outputs 0 the next cycle, no response produced, next tie goes to requester 0.
